// File: rtl/sequencer_ws.sv
// Control sequencer for the accumulator CPU: fetch/decode/execute FSM with memory
// ready handshake, wait-state timeout, HALT and FAULT. Optional retire counter: SEQ_PERF_CNT_EN.
module sequencer_ws #(
  parameter int WORD_W  = 8,
  parameter int OP_W    = 4,
  parameter int TMO_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             z_flag,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             ACC_bus,
  output logic             load_ACC,
  output logic             PC_bus,
  output logic             load_PC,
  output logic             load_IR,
  output logic             load_MAR,
  output logic             MDR_bus,
  output logic             load_MDR,
  output logic             ALU_ACC,
  output logic             ALU_add,
  output logic             ALU_sub,
  output logic             ALU_xor,
  output logic             INC_PC,
  output logic             Addr_bus,
  output logic             CS,
  output logic             R_NW,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'b0011);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4'b0100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4'b0101);
  localparam logic [OP_W-1:0] OP_DEREF = OP_W'(4'b0110);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4'b0111);
  localparam logic [OP_W-1:0] OP_JMP   = OP_W'(4'b1000);
  localparam logic [OP_W-1:0] OP_LDI   = OP_W'(4'b1001);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(4'b1111);

  localparam logic [1:0]       CODE_TMO = 2'b01;
  localparam logic [1:0]       CODE_ILL = 2'b10;
  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  // A timeout that the counter can never reach would silently disable the fault path.
  generate
    if (OP_W < 4 || WORD_W < 1 || TMO_W < 1 || TIMEOUT < 0 || TIMEOUT > (2 ** TMO_W) - 1) begin : g_bad_params
      $error("sequencer_ws: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_FETCH0,
    S_FETCH_RD,
    S_FETCH_IR,
    S_DECODE,
    S_ST_MDR,
    S_ST_WR,
    S_OPER_RD,
    S_EXEC_LD,
    S_EXEC_ALU,
    S_DR_MAR,
    S_DR_RD,
    S_DR_ACC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t           state_reg;
  logic [TMO_W-1:0] wait_cnt_reg;
  logic             halted_reg;
  logic             fault_reg;
  logic [1:0]       fault_code_reg;

  logic is_load, is_store, is_alu, is_deref, is_beq, is_bne, is_jmp, is_ldi, is_halt, is_legal;
  logic wait_st, tmo_hit, retire;

  assign is_load  = (op == OP_LOAD);
  assign is_store = (op == OP_STORE);
  assign is_alu   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  assign is_deref = (op == OP_DEREF);
  assign is_beq   = (op == OP_BEQ);
  assign is_bne   = (op == OP_BNE);
  assign is_jmp   = (op == OP_JMP);
  assign is_ldi   = (op == OP_LDI);
  assign is_halt  = (op == OP_HALT);
  assign is_legal = is_load || is_store || is_alu || is_deref || is_beq || is_bne ||
                    is_jmp || is_ldi || is_halt;

  assign wait_st = (state_reg == S_FETCH_RD) || (state_reg == S_ST_WR) ||
                   (state_reg == S_OPER_RD)  || (state_reg == S_DR_RD);
  // Ready in the same cycle as the limit wins, hence the !mem_ready term.
  assign tmo_hit = TMO_EN && wait_st && !mem_ready && (wait_cnt_reg == TMO_LIM);

  // Strobes are a pure function of state (plus op/z_flag in DECODE and EXEC_ALU).
  // retire marks every cycle whose successor is FETCH0.
  always_comb begin
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    load_IR  = 1'b0;
    load_MAR = 1'b0;
    MDR_bus  = 1'b0;
    load_MDR = 1'b0;
    ALU_ACC  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    ALU_xor  = 1'b0;
    INC_PC   = 1'b0;
    Addr_bus = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    retire   = 1'b0;
    case (state_reg)
      S_FETCH0: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        INC_PC   = 1'b1;
        load_PC  = 1'b1;
      end
      S_FETCH_RD: begin
        CS   = 1'b1;
        R_NW = 1'b1;
      end
      S_FETCH_IR: begin
        MDR_bus = 1'b1;
        load_IR = 1'b1;
      end
      S_DECODE: begin
        Addr_bus = 1'b1;
        load_MAR = 1'b1;
        load_ACC = is_ldi;
        load_PC  = is_jmp || (is_beq && z_flag) || (is_bne && !z_flag);
        retire   = is_ldi || is_jmp || is_beq || is_bne;
      end
      S_ST_MDR: begin
        ACC_bus  = 1'b1;
        load_MDR = 1'b1;
      end
      S_ST_WR: begin
        CS     = 1'b1;
        retire = mem_ready;
      end
      S_OPER_RD: begin
        CS   = 1'b1;
        R_NW = 1'b1;
      end
      S_EXEC_LD: begin
        MDR_bus  = 1'b1;
        load_ACC = 1'b1;
        retire   = 1'b1;
      end
      S_EXEC_ALU: begin
        MDR_bus  = 1'b1;
        ALU_ACC  = 1'b1;
        load_ACC = 1'b1;
        ALU_add  = (op == OP_ADD);
        ALU_sub  = (op == OP_SUB);
        ALU_xor  = (op == OP_XOR);
        retire   = 1'b1;
      end
      S_DR_MAR: begin
        ACC_bus  = 1'b1;
        load_MAR = 1'b1;
      end
      S_DR_RD: begin
        CS   = 1'b1;
        R_NW = 1'b1;
      end
      S_DR_ACC: begin
        MDR_bus  = 1'b1;
        load_ACC = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_reg      <= S_FETCH0;
      wait_cnt_reg   <= '0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      fault_code_reg <= 2'b00;
    end else begin
      // Any exit from a wait state leaves the counter at zero for the next entry.
      if (wait_st && !mem_ready && !tmo_hit)
        wait_cnt_reg <= (wait_cnt_reg == TMO_MAX) ? wait_cnt_reg : wait_cnt_reg + TMO_W'(1);
      else
        wait_cnt_reg <= '0;

      if (tmo_hit) begin
        state_reg      <= S_FAULT;
        fault_reg      <= 1'b1;
        fault_code_reg <= CODE_TMO;
      end else if (retire) begin
        state_reg <= S_FETCH0;
      end else begin
        case (state_reg)
          S_FETCH0:   state_reg <= S_FETCH_RD;
          S_FETCH_RD: if (mem_ready) state_reg <= S_FETCH_IR;
          S_FETCH_IR: state_reg <= S_DECODE;
          S_DECODE: begin
            if (is_store)
              state_reg <= S_ST_MDR;
            else if (is_load || is_alu)
              state_reg <= S_OPER_RD;
            else if (is_deref)
              state_reg <= S_DR_MAR;
            else if (is_halt) begin
              state_reg  <= S_HALT;
              halted_reg <= 1'b1;
            end else if (!is_legal) begin
              state_reg      <= S_FAULT;
              fault_reg      <= 1'b1;
              fault_code_reg <= CODE_ILL;
            end
          end
          S_ST_MDR:   state_reg <= S_ST_WR;
          S_OPER_RD:  if (mem_ready) state_reg <= is_load ? S_EXEC_LD : S_EXEC_ALU;
          S_DR_MAR:   state_reg <= S_DR_RD;
          S_DR_RD:    if (mem_ready) state_reg <= S_DR_ACC;
          default:    state_reg <= state_reg;
        endcase
      end
    end
  end

  assign halted     = halted_reg;
  assign fault      = fault_reg;
  assign fault_code = fault_code_reg;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_reg;

  always_ff @(posedge clock) begin
    if (!n_reset)
      instr_count_reg <= '0;
    else if (retire)
      instr_count_reg <= instr_count_reg + CNT_W'(1);
  end

  assign instr_count = instr_count_reg;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_sequencer_ws.sv
// Bench for sequencer_ws: per-instruction cycle plans (strobes, ready, z, op) built from
// the instruction rules and replayed against the DUT with randomized wait states.
`timescale 1ns/1ps
module tb_sequencer_ws;
  localparam int OP_W       = 4;
  localparam int TMO_W      = 4;
  localparam int TIMEOUT    = 15;
  localparam int CNT_W      = 4;
  localparam int WAIT_LIMIT = TIMEOUT + 1;

  localparam logic [3:0] OP_LOAD = 4'b0000, OP_STORE = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0011,
                         OP_XOR = 4'b0100, OP_BNE = 4'b0101, OP_DEREF = 4'b0110, OP_BEQ = 4'b0111,
                         OP_JMP = 4'b1000, OP_LDI = 4'b1001, OP_HALT = 4'b1111;

  localparam logic [15:0] M_ACC_BUS = 16'h8000, M_LOAD_ACC = 16'h4000, M_PC_BUS = 16'h2000,
                          M_LOAD_PC = 16'h1000, M_LOAD_IR = 16'h0800, M_LOAD_MAR = 16'h0400,
                          M_MDR_BUS = 16'h0200, M_LOAD_MDR = 16'h0100, M_ALU_ACC = 16'h0080,
                          M_ALU_ADD = 16'h0040, M_ALU_SUB = 16'h0020, M_ALU_XOR = 16'h0010,
                          M_INC_PC = 16'h0008, M_ADDR_BUS = 16'h0004, M_CS = 16'h0002, M_R_NW = 16'h0001;

  localparam int K_RET = 0, K_HALT = 1, K_ILL = 2, K_TMO = 3;

  logic clock = 1'b0, n_reset = 1'b0, z_flag = 1'b0, mem_ready = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR;
  logic ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW;
  logic halted, fault;
  logic [1:0] fault_code;
  logic [CNT_W-1:0] instr_count;
  logic [15:0] strb_obs;

  sequencer_ws #(.WORD_W(8), .OP_W(OP_W), .TMO_W(TMO_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .n_reset(n_reset), .z_flag(z_flag), .op(op), .mem_ready(mem_ready),
    .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
    .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
    .ALU_ACC(ALU_ACC), .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_xor(ALU_xor),
    .INC_PC(INC_PC), .Addr_bus(Addr_bus), .CS(CS), .R_NW(R_NW),
    .halted(halted), .fault(fault), .fault_code(fault_code), .instr_count(instr_count)
  );

  assign strb_obs = {ACC_bus, load_ACC, PC_bus, load_PC, load_IR, load_MAR, MDR_bus, load_MDR,
                     ALU_ACC, ALU_add, ALU_sub, ALU_xor, INC_PC, Addr_bus, CS, R_NW};

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] strb;
    logic        rdy;
    logic        z;
    logic [3:0]  op;
  } cyc_t;

  cyc_t plan[$];
  int tests = 0, fails = 0, retired = 0, cycle_no = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef SEQ_PERF_CNT_EN
    return CNT_W'(retired);
`else
    return '0;
`endif
  endfunction

  function automatic void push(input logic [15:0] s, input logic r, input logic z, input logic [3:0] o);
    cyc_t c;
    c.strb = s; c.rdy = r; c.z = z; c.op = o;
    plan.push_back(c);
  endfunction

  // d cycles of mem_ready=0 then one ready cycle; returns 1 if d reaches the timeout.
  function automatic int push_mem(input logic [15:0] s, input int d, input logic [3:0] o);
    for (int i = 0; i < d && i < WAIT_LIMIT; i++) push(s, 1'b0, rbit(), o);
    if (d >= WAIT_LIMIT) return 1;
    push(s, 1'b1, rbit(), o);
    return 0;
  endfunction

  function automatic int plan_instr(input logic [3:0] o, input logic z, input int df, input int dm);
    logic [15:0] dec;
    logic [15:0] alu;
    push(M_PC_BUS | M_LOAD_MAR | M_INC_PC | M_LOAD_PC, rbit(), rbit(), 4'($urandom));
    if (push_mem(M_CS | M_R_NW, df, 4'($urandom)) != 0) return K_TMO;
    push(M_MDR_BUS | M_LOAD_IR, rbit(), rbit(), 4'($urandom));
    dec = M_ADDR_BUS | M_LOAD_MAR;
    if (o == OP_LDI) dec |= M_LOAD_ACC;
    if (o == OP_JMP || (o == OP_BEQ && z) || (o == OP_BNE && !z)) dec |= M_LOAD_PC;
    push(dec, rbit(), z, o);
    alu = (o == OP_ADD) ? M_ALU_ADD : (o == OP_SUB) ? M_ALU_SUB : M_ALU_XOR;
    case (o)
      OP_LDI, OP_JMP, OP_BEQ, OP_BNE: return K_RET;
      OP_HALT: return K_HALT;
      OP_STORE: begin
        push(M_ACC_BUS | M_LOAD_MDR, rbit(), rbit(), o);
        return (push_mem(M_CS, dm, o) != 0) ? K_TMO : K_RET;
      end
      OP_LOAD: begin
        if (push_mem(M_CS | M_R_NW, dm, o) != 0) return K_TMO;
        push(M_MDR_BUS | M_LOAD_ACC, rbit(), rbit(), o);
        return K_RET;
      end
      OP_ADD, OP_SUB, OP_XOR: begin
        if (push_mem(M_CS | M_R_NW, dm, o) != 0) return K_TMO;
        push(M_MDR_BUS | M_ALU_ACC | M_LOAD_ACC | alu, rbit(), rbit(), o);
        return K_RET;
      end
      OP_DEREF: begin
        push(M_ACC_BUS | M_LOAD_MAR, rbit(), rbit(), o);
        if (push_mem(M_CS | M_R_NW, dm, o) != 0) return K_TMO;
        push(M_MDR_BUS | M_LOAD_ACC, rbit(), rbit(), o);
        return K_RET;
      end
      default: return K_ILL;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input logic h, input logic f, input logic [1:0] code);
    check($sformatf("halted c%0d", cycle_no), 32'(halted), 32'(h));
    check($sformatf("fault c%0d", cycle_no), 32'(fault), 32'(f));
    check($sformatf("fault_code c%0d", cycle_no), 32'(fault_code), 32'(code));
    check($sformatf("instr_count c%0d", cycle_no), 32'(instr_count), 32'(exp_count()));
  endtask

  task automatic run_plan(input int max_n);
    cyc_t c;
    int n;
    n = 0;
    while (plan.size() > 0 && n < max_n) begin
      c = plan.pop_front();
      @(negedge clock);
      op = c.op; z_flag = c.z; mem_ready = c.rdy;
      #1;
      check($sformatf("strobes c%0d", cycle_no), 32'(strb_obs), 32'(c.strb));
      check_flags(1'b0, 1'b0, 2'b00);
      cycle_no++;
      n++;
    end
  endtask

  task automatic check_term(input logic h, input logic f, input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      op = 4'($urandom); z_flag = rbit(); mem_ready = rbit();
      #1;
      check($sformatf("term strobes c%0d", cycle_no), 32'(strb_obs), 32'(0));
      check_flags(h, f, code);
      cycle_no++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    n_reset = 1'b0; mem_ready = 1'b0;
    @(posedge clock);
    #1 n_reset = 1'b1;
    retired = 0;
    $display("[TB] reset at t=%0t", $time);
  endtask

  task automatic run_instr(input logic [3:0] o, input logic z, input int df, input int dm);
    int k;
    k = plan_instr(o, z, df, dm);
    run_plan(1000);
    case (k)
      K_RET:   retired++;
      K_HALT:  check_term(1'b1, 1'b0, 2'b00, 4);
      K_ILL:   check_term(1'b0, 1'b1, 2'b10, 4);
      default: check_term(1'b0, 1'b1, 2'b01, 4);
    endcase
    $display("[TB] op=%b z=%0d fetch_wait=%0d mem_wait=%0d outcome=%0d retired=%0d",
             o, z, df, dm, k, retired);
    if (k != K_RET) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    do_reset();
    // Ready tied high: LDI / ADD / STORE timing and strobes.
    run_instr(OP_LDI, rbit(), 0, 0);
    run_instr(OP_ADD, rbit(), 0, 0);
    run_instr(OP_STORE, rbit(), 0, 0);
    run_instr(OP_DEREF, rbit(), 0, 0);
    // Fetch held off three cycles; ready at the timeout limit wins.
    run_instr(OP_JMP, 1'b0, 3, 0);
    run_instr(OP_LOAD, rbit(), 15, 15);
    run_instr(OP_XOR, rbit(), 0, 15);
    // Branch decisions on z_flag sampled in DECODE.
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BNE, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 1, 0);
    run_instr(OP_BNE, 1'b0, 0, 0);
    // Reset in the middle of an operand read that is being held off.
    k = plan_instr(OP_LOAD, 1'b0, 0, 99);
    run_plan(6);
    plan.delete();
    @(negedge clock);
    n_reset = 1'b0; mem_ready = 1'b0;
    #1 check("cs before reset", 32'(CS), 32'(1));
    @(posedge clock);
    #1 n_reset = 1'b1;
    retired = 0;
    @(negedge clock);
    #1;
    check("reset mid-access strobes", 32'(strb_obs), 32'(M_PC_BUS | M_LOAD_MAR | M_INC_PC | M_LOAD_PC));
    check("reset mid-access cs", 32'(CS), 32'(0));
    check("reset mid-access fault", 32'(fault), 32'(0));
    check("reset mid-access halted", 32'(halted), 32'(0));
    $display("[TB] mid-access reset checked");
    do_reset();
    // Timeouts in fetch, store write and deref read.
    run_instr(OP_JMP, 1'b0, 16, 0);
    run_instr(OP_STORE, 1'b0, 1, 16);
    run_instr(OP_DEREF, 1'b0, 0, 40);
    // Illegal opcodes.
    run_instr(4'b1010, 1'b0, 0, 0);
    run_instr(4'($urandom_range(11, 14)), rbit(), $urandom_range(0, 3), 0);
    // Seventeen jumps wrap a 4-bit retire counter, then HALT freezes it.
    for (int i = 0; i < 17; i++) run_instr(OP_JMP, rbit(), $urandom_range(0, 2), 0);
    run_instr(OP_HALT, rbit(), 0, 0);
    // Randomized legal instruction mix with random wait states.
    for (int i = 0; i < 40; i++) begin
      run_instr(4'($urandom_range(0, 9)), rbit(),
                ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
